// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//
// Bit-serial two's-complement subtractor: diff = a - b - bin (mod 2^N).
// One full-subtractor cell with a borrow flop processes one bit per clock,
// LSB first. Operands enter and results leave over valid/ready handshakes.
//
// Handshake rule (both sides): a transfer happens on a rising edge where
// valid && ready are both 1 and rst is 0. Ready/valid outputs are decoded
// from the FSM state only, so there is no combinational path from in_valid
// or out_ready to in_ready or out_valid.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands valid
//   in_ready   block can accept operands (IDLE only)
//   a, b       minuend / subtrahend, N bits
//   bin        borrow in
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   diff       a - b - bin mod 2^N
//   bout       borrow out of the MSB (unsigned a < b + bin)
//   ovf        signed overflow
//   zero       diff == 0
//   dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// -----------------------------------------------------------------------------
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         ovf,
  output logic         zero,
  output logic [1:0]   dbg_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);
  localparam logic [CW-1:0] MSB_IN   = CW'(N - 2);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [N-1:0]  r_a_sh;
  logic [N-1:0]  r_b_sh;
  logic [N-1:0]  r_d_sh;
  logic [CW-1:0] r_cnt;
  logic          r_borrow;
  logic          r_bmsb;   // borrow into the MSB, kept for overflow
  logic          r_bout;
  logic          r_ovf;
  logic          r_zero;

  logic          w_ai;
  logic          w_bi;
  logic          w_d;
  logic          w_bo;
  logic          w_last;
  logic [N-1:0]  w_d_next;

  // Full-subtractor cell.
  assign w_ai     = r_a_sh[0];
  assign w_bi     = r_b_sh[0];
  assign w_d      = w_ai ^ w_bi ^ r_borrow;
  assign w_bo     = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_borrow);
  assign w_last   = (r_cnt == LAST_BIT);
  assign w_d_next = {w_d, r_d_sh[N-1:1]};

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs decoded from state only.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE:  in_ready  = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: ;
    endcase
  end

  // Datapath. Nothing moves in DONE, so the result stays stable under stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_d_sh   <= '0;
      r_cnt    <= '0;
      r_borrow <= 1'b0;
      r_bmsb   <= 1'b0;
      r_bout   <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a_sh   <= a;
            r_b_sh   <= b;
            r_borrow <= bin;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_a_sh   <= {1'b0, r_a_sh[N-1:1]};
          r_b_sh   <= {1'b0, r_b_sh[N-1:1]};
          r_d_sh   <= w_d_next;
          r_borrow <= w_bo;
          r_cnt    <= r_cnt + 1'b1;
          // Borrow out of bit N-2 is the borrow into the MSB.
          if (r_cnt == MSB_IN) begin
            r_bmsb <= w_bo;
          end
          if (w_last) begin
            r_bout <= w_bo;
            r_ovf  <= r_bmsb ^ w_bo;
            r_zero <= (w_d_next == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign diff      = r_d_sh;
  assign bout      = r_bout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//
// Bench for serial_subtractor with N = 8. Expected results come from plain
// integer arithmetic; expected handshake timing comes from the accept edge
// number plus the fixed N-cycle latency.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

  localparam int N = 8;

  // ---------------------------------------------------------------- clock/reset
  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] diff;
  logic         bout;
  logic         ovf;
  logic         zero;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  serial_subtractor #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
    .ovf       (ovf),
    .zero      (zero),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------- counters
  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  // ---------------------------------------------------------------- model
  // Result packed as {diff[7:0], bout, ovf, zero}.
  function automatic logic [N+2:0] model(input logic [N-1:0] av, input logic [N-1:0] bv,
                                         input logic bi);
    int           ua, ub, sa, sb, sd;
    logic [N-1:0] d;
    ua = int'(av);
    ub = int'(bv);
    sa = int'($signed(av));
    sb = int'($signed(bv));
    sd = sa - sb - int'(bi);
    d  = N'(ua - ub - int'(bi));
    return {d, (ua < ub + int'(bi)), (sd < -(1 << (N-1))) || (sd > (1 << (N-1)) - 1), (d == '0)};
  endfunction

  // Scoreboard: expected queue plus accept-edge timestamp.
  logic [N+2:0] exp_q[$];
  int  cyc       = 0;
  int  m_acc     = 0;
  bit  m_busy    = 0;
  bit  m_live    = 0;
  bit  m_rst_last = 0;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_busy     = 0;
        m_live     = 1;
        m_rst_last = 1;
        exp_q.delete();
      end else begin
        m_rst_last = 0;
        if (m_busy) begin
          if ((cyc - 1 >= m_acc + N) && out_ready) begin
            m_busy = 0;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
          end
        end else if (in_valid) begin
          m_busy = 1;
          m_acc  = cyc;
          exp_q.push_back(model(a, b, bin));
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  initial begin
    logic         exp_ov;
    logic [N+2:0] e;
    forever begin
      @(negedge clk);
      if (m_live) begin
        exp_ov = m_busy && (cyc >= m_acc + N);
        chk("in_ready", 32'(in_ready), 32'(!m_busy));
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        if (exp_ov && exp_q.size() > 0) begin
          e = exp_q[0];
          chk("diff", 32'(diff), 32'(e[N+2:3]));
          chk("bout", 32'(bout), 32'(e[2]));
          chk("ovf",  32'(ovf),  32'(e[1]));
          chk("zero", 32'(zero), 32'(e[0]));
        end
        if (m_rst_last) begin
          chk("rst_result", 32'({diff, bout, ovf, zero}), 32'(0));
        end
      end
    end
  end

  // ---------------------------------------------------------------- driver
  // Entered and left at posedge+1.
  task automatic do_op(input logic [N-1:0] av, input logic [N-1:0] bv, input logic bi,
                       input int stall, input bit lit, input logic [N+2:0] lit_exp);
    bit got;
    int n;
    a = av; b = bv; bin = bi; in_valid = 1'b1; out_ready = 1'b0;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (in_ready) got = 1;
    end
    if (!got) begin
      fail_now("accept_wait");
      @(posedge clk); #1 in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
    n = 0; got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (out_valid) got = 1;
    end
    if (!got) begin
      fail_now("result_wait");
      return;
    end
    chk("latency", 32'(n), 32'(N));
    if (lit) chk("literal", 32'({diff, bout, ovf, zero}), 32'(lit_exp));
    if (stall > 0) begin
      in_valid = 1'b1;
      repeat (stall) begin
        @(posedge clk);
        #1;
        a = N'($urandom); b = N'($urandom); bin = 1'($urandom);
      end
      @(negedge clk);
      if (lit) begin
        chk("stall_hold", 32'({diff, bout, ovf, zero}), 32'(lit_exp));
        chk("stall_in_ready", 32'(in_ready), 32'(0));
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    if (lit) begin
      chk("drop_out_valid", 32'(out_valid), 32'(0));
      chk("back_in_ready", 32'(in_ready), 32'(1));
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic [N-1:0] pick();
    logic [N-1:0] corners[4];
    corners[0] = 8'h00; corners[1] = 8'h7F; corners[2] = 8'h80; corners[3] = 8'hFF;
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 3)];
    return N'($urandom);
  endfunction

  // ---------------------------------------------------------------- stimulus
  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_in_ready", 32'(in_ready), 32'(1));
    chk("reset_out_valid", 32'(out_valid), 32'(0));
    chk("reset_result", 32'({diff, bout, ovf, zero}), 32'(0));
    @(posedge clk);
    #1;

    // Directed cases with hand-computed results {diff, bout, ovf, zero}.
    do_op(8'h35, 8'h12, 1'b0, 0, 1, {8'h23, 1'b0, 1'b0, 1'b0});
    do_op(8'h12, 8'h35, 1'b0, 0, 1, {8'hDD, 1'b1, 1'b0, 1'b0});
    do_op(8'h80, 8'h01, 1'b0, 0, 1, {8'h7F, 1'b0, 1'b1, 1'b0});
    do_op(8'h00, 8'h00, 1'b1, 0, 1, {8'hFF, 1'b1, 1'b0, 1'b0});
    do_op(8'h05, 8'h04, 1'b1, 0, 1, {8'h00, 1'b0, 1'b0, 1'b1});

    // Backpressure with toggling operands and in_valid held high.
    do_op(8'h35, 8'h12, 1'b0, 5, 1, {8'h23, 1'b0, 1'b0, 1'b0});

    // Reset three edges after accept.
    a = 8'hA5; b = 8'h3C; bin = 1'b1; in_valid = 1'b1;
    begin
      bit got;
      got = 0;
      for (int k = 0; k < 20 && !got; k++) begin
        @(negedge clk);
        if (in_ready) got = 1;
      end
      if (!got) fail_now("rst_accept_wait");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrun_out_valid", 32'(out_valid), 32'(0));
    chk("midrun_in_ready", 32'(in_ready), 32'(1));
    chk("midrun_result", 32'({diff, bout, ovf, zero}), 32'(0));
    @(posedge clk);
    #1;
    do_op(8'h35, 8'h12, 1'b0, 0, 1, {8'h23, 1'b0, 1'b0, 1'b0});

    // Random operations with random stalls and idle gaps.
    for (int i = 0; i < 150; i++) begin
      do_op(pick(), pick(), 1'($urandom), $urandom_range(0, 3), 0, '0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Watchdog.
  initial begin
    #1_000_000;
    fail_now("watchdog");
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule
